// File: rtl/winocnn_pkg.sv
// rtl/winocnn_pkg.sv - shared tile geometry, tile/entry types and writer FSM states
package winocnn_pkg;

   localparam int TILE_DIM = 4;
   localparam int ELEM_W   = 32;
   localparam int WORD_W   = TILE_DIM * TILE_DIM * ELEM_W;
   localparam int ADDR_W   = 8;

   // Element [r][c] lands at bits (r*TILE_DIM+c)*ELEM_W, so a tile maps 1:1 onto a memory word
   typedef logic signed [TILE_DIM-1:0][TILE_DIM-1:0][ELEM_W-1:0] tile_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      tile_t             tile;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic tile_t relu_tile(input tile_t t);
      tile_t o;
      o = t;
      for (int r = 0; r < TILE_DIM; r++) begin
         for (int c = 0; c < TILE_DIM; c++) begin
            if (t[r][c][ELEM_W-1]) o[r][c] = '0;
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous FIFO of {addr, tile} entries with full/empty flags
module result_fifo
   import winocnn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  fifo_entry_t push_data,
   input  logic        pop,
   output fifo_entry_t pop_data,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   fifo_entry_t      store [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   // Caller only pushes when not full and pops when not empty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   assign pop_data = store[rd_ptr];
   assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);

endmodule

// File: rtl/result_mem_writer.sv
// rtl/result_mem_writer.sv - merges two PE tile streams into one SRAM write port
// Optional macro RESULT_RELU_EN clamps negative elements to zero at write-out.
module result_mem_writer
   import winocnn_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [7:0]          block_cnt_i,
   input  tile_t               result_tile_i_1,
   input  logic [ADDR_W-1:0]   result_addr_i_1,
   input  logic                result_valid_i_1,
   output logic                result_ready_o_1,
   input  tile_t               result_tile_i_2,
   input  logic [ADDR_W-1:0]   result_addr_i_2,
   input  logic                result_valid_i_2,
   output logic                result_ready_o_2,
   output logic                mem_wen_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [WORD_W-1:0]   mem_data_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [7:0]          write_cnt_o
);

   state_t      state;
   logic [7:0]  blk_cnt;
   logic [7:0]  acc_cnt;
   logic        rr_ptr;
   logic        run;
   logic        room;
   logic        last_slot;
   logic        push_1, push_2;
   logic        pop_1, pop_2;
   logic        full_1, full_2;
   logic        empty_1, empty_2;
   logic        contested;
   fifo_entry_t in_1, in_2;
   fifo_entry_t out_1, out_2;
   fifo_entry_t wr_entry;
   tile_t       wr_tile;

   assign run       = (state == ST_RUN);
   assign room      = (acc_cnt < blk_cnt);
   assign last_slot = (acc_cnt == blk_cnt - 8'd1);

   // With one slot left and both ports offering, port 1 takes it
   assign result_ready_o_1 = run && !full_1 && room;
   assign result_ready_o_2 = run && !full_2 && room &&
                             !(result_valid_i_1 && result_ready_o_1 && last_slot);

   assign push_1 = result_valid_i_1 && result_ready_o_1;
   assign push_2 = result_valid_i_2 && result_ready_o_2;

   assign in_1 = {result_addr_i_1, result_tile_i_1};
   assign in_2 = {result_addr_i_2, result_tile_i_2};

   result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_1 (
      .clk       (clk),
      .reset     (reset),
      .push      (push_1),
      .push_data (in_1),
      .pop       (pop_1),
      .pop_data  (out_1),
      .full      (full_1),
      .empty     (empty_1)
   );

   result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_2 (
      .clk       (clk),
      .reset     (reset),
      .push      (push_2),
      .push_data (in_2),
      .pop       (pop_2),
      .pop_data  (out_2),
      .full      (full_2),
      .empty     (empty_2)
   );

   assign contested = run && !empty_1 && !empty_2;

   // rr_ptr = 0 favours port 1 on the next contested cycle
   always_comb begin
      pop_1 = 1'b0;
      pop_2 = 1'b0;
      if (contested) begin
         if (rr_ptr) pop_2 = 1'b1;
         else        pop_1 = 1'b1;
      end else if (run && !empty_1) begin
         pop_1 = 1'b1;
      end else if (run && !empty_2) begin
         pop_2 = 1'b1;
      end
   end

   assign wr_entry = pop_2 ? out_2 : out_1;

`ifdef RESULT_RELU_EN
   assign wr_tile = relu_tile(wr_entry.tile);
`else
   assign wr_tile = wr_entry.tile;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         blk_cnt     <= '0;
         acc_cnt     <= '0;
         rr_ptr      <= 1'b0;
         mem_wen_o   <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         write_cnt_o <= '0;
      end else begin
         mem_wen_o <= pop_1 || pop_2;
         if (pop_1 || pop_2) begin
            mem_addr_o  <= wr_entry.addr;
            mem_data_o  <= wr_tile;
            write_cnt_o <= write_cnt_o + 8'd1;
         end
         if (contested) rr_ptr <= ~rr_ptr;
         acc_cnt <= acc_cnt + 8'(push_1) + 8'(push_2);

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  blk_cnt     <= block_cnt_i;
                  acc_cnt     <= '0;
                  write_cnt_o <= '0;
                  state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (write_cnt_o == blk_cnt && empty_1 && empty_2) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o = (state != ST_IDLE);
   assign done_o = (state == ST_DONE);

endmodule
